// File: rtl/kyber_pkg.sv
// Shared constants and types for the bit/byte stream converters.
package kyber_pkg;

  localparam int MAX_W = 12;

  // The accumulator holds up to seven leftover bits plus one full chunk.
  function automatic int acc_width(input int max_w);
    return max_w + 8;
  endfunction

  localparam int ACC_W = acc_width(MAX_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bits_acc.sv
// LSB-first bit accumulator: appends masked chunks above the held bits and
// retires the low byte on request.
module bits_acc
  import kyber_pkg::*;
#(
  parameter int MAX_W = kyber_pkg::MAX_W
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   clear,
  input  logic                                   append_en,
  input  logic [MAX_W-1:0]                       append_bits,
  input  logic [3:0]                             append_cnt,
  input  logic                                   shift_en,
  output logic [7:0]                             acc_byte,
  output logic [$clog2(acc_width(MAX_W)+1)-1:0] acc_cnt
);

  localparam int AW = acc_width(MAX_W);
  localparam int CW = $clog2(AW + 1);

  logic [AW-1:0]    acc;
  logic [MAX_W-1:0] masked;
  logic [AW-1:0]    masked_ext;

  // Bits beyond append_cnt are forced to zero so the upper accumulator stays clean.
  always_comb begin
    masked = '0;
    for (int i = 0; i < MAX_W; i++) begin
      masked[i] = append_bits[i] & (i < int'(append_cnt));
    end
    masked_ext = AW'(masked) << acc_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (append_en) begin
      acc     <= acc | masked_ext;
      acc_cnt <= acc_cnt + CW'(append_cnt);
    end else if (shift_en) begin
      acc     <= acc >> 8;
      acc_cnt <= acc_cnt - CW'(8);
    end
  end

  assign acc_byte = acc[7:0];

endmodule

// File: rtl/bits_to_bytes_stream.sv
// Packs variable-width input chunks LSB-first into a framed stream of bytes
// with valid/ready handshakes on both sides.
module bits_to_bytes_stream
  import kyber_pkg::*;
#(
  parameter int BYTE_COUNT = 384,
  parameter int MAX_W      = kyber_pkg::MAX_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [$clog2(BYTE_COUNT):0] len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MAX_W-1:0]            in_bits,
  input  logic [3:0]                  in_width,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [7:0]                  out_byte,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int LW = $clog2(BYTE_COUNT) + 1;
  localparam int BW = LW + 3;
  localparam int AW = acc_width(MAX_W);
  localparam int CW = $clog2(AW + 1);

  state_t        state, state_next;
  logic [LW-1:0] len_r, byte_cnt;
  logic [BW-1:0] bit_cnt, total_bits, room;
  logic [CW-1:0] acc_cnt;
  logic [3:0]    keep;
  logic          width_bad, trunc, in_fire, out_fire, start_ok, err_r;

  assign start_ok   = (state == IDLE) && start;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign total_bits = {len_r, 3'b000};
  assign room       = total_bits - bit_cnt;

  // Malformed widths append nothing; oversize chunks keep only what still fits.
  assign width_bad = (in_width == 4'd0) || (int'(in_width) > MAX_W);
  assign trunc     = !width_bad && (BW'(in_width) > room);
  assign keep      = width_bad ? 4'd0 : (trunc ? room[3:0] : in_width);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (len == '0) ? DONE : PACK;
      PACK:    if (in_fire && ((bit_cnt + BW'(keep)) == total_bits)) state_next = DRAIN;
      DRAIN:   if (out_fire && out_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Input and output sides are mutually exclusive on acc_cnt, so no cycle moves both.
  always_comb begin
    in_ready  = (state == PACK) && (acc_cnt < CW'(8));
    out_valid = ((state == PACK) || (state == DRAIN)) && (acc_cnt >= CW'(8));
    out_last  = out_valid && (byte_cnt == (len_r - 1'b1));
    busy      = (state == PACK) || (state == DRAIN);
    done      = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_r    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      err_r    <= 1'b0;
    end else begin
      if (start_ok) begin
        len_r    <= len;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        err_r    <= (len == '0);
      end
      if (in_fire) begin
        bit_cnt <= bit_cnt + BW'(keep);
        if (width_bad || trunc) err_r <= 1'b1;
      end
      if (out_fire) byte_cnt <= byte_cnt + 1'b1;
    end
  end

  assign err = err_r;

  bits_acc #(
    .MAX_W(MAX_W)
  ) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .append_en  (in_fire),
    .append_bits(in_bits),
    .append_cnt (keep),
    .shift_en   (out_fire),
    .acc_byte   (out_byte),
    .acc_cnt    (acc_cnt)
  );

endmodule

// File: tb/tb_bits_to_bytes_stream.sv
// Table-driven bench for bits_to_bytes_stream plus hand-written sequences
// for backpressure and mid-frame reset.
module tb_bits_to_bytes_stream;

  localparam int BYTE_COUNT = 384;
  localparam int MAX_W      = 12;
  localparam int LW         = 10;

  typedef struct packed {
    logic [9:0]        len;
    logic [3:0]        n_chunks;
    logic [7:0][11:0]  bits;
    logic [7:0][3:0]   widths;
    logic [2:0]        n_bytes;
    logic [3:0][7:0]   bytes;
    logic              exp_err;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LW-1:0]    len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [MAX_W-1:0] in_bits = '0;
  logic [3:0]       in_width = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [7:0]       out_byte;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             err;

  vec_t       vecs[8];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         done_cnt, done_cyc, last_cyc, start_cyc;
  logic       accepted;
  logic [7:0] got_bytes[$];
  logic       got_last[$];

  bits_to_bytes_stream #(
    .BYTE_COUNT(BYTE_COUNT),
    .MAX_W     (MAX_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bits  (in_bits),
    .in_width (in_width),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_byte (out_byte),
    .out_last (out_last),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Records the handshakes that complete at the coming edge, then advances to #1 after it.
  task automatic tick();
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      got_bytes.push_back(out_byte);
      got_last.push_back(out_last);
      if (out_last) last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clearCapture();
    got_bytes.delete();
    got_last.delete();
    done_cnt = 0;
    done_cyc = -1;
    last_cyc = -1;
  endtask

  task automatic startFrame(input logic [9:0] l);
    clearCapture();
    start     = 1'b1;
    len       = l;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    len   = '0;
  endtask

  task automatic sendChunk(input logic [11:0] b, input logic [3:0] w);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_bits  = b;
    in_width = w;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      ok = accepted;
    end
    in_valid = 1'b0;
    in_bits  = '0;
    in_width = '0;
    if (!ok) checkValue("chunk accept timeout", 32'(ok), 32'd1);
  endtask

  task automatic waitDone();
    for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
    tick();
    tick();
  endtask

  task automatic applyStimulus(input vec_t v);
    startFrame(v.len);
    for (int c = 0; c < int'(v.n_chunks); c++) sendChunk(v.bits[c], v.widths[c]);
    waitDone();
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    int ref_cyc;
    checkValue($sformatf("%s byte count", tag), 32'(got_bytes.size()), 32'(v.n_bytes));
    for (int i = 0; i < int'(v.n_bytes); i++) begin
      if (i < got_bytes.size()) begin
        checkValue($sformatf("%s byte %0d", tag, i), 32'(got_bytes[i]), 32'(v.bytes[i]));
        checkValue($sformatf("%s last %0d", tag, i), 32'(got_last[i]), 32'(i == int'(v.n_bytes) - 1));
      end
    end
    ref_cyc = (v.n_bytes != 0) ? last_cyc : start_cyc;
    checkValue($sformatf("%s done count", tag), 32'(done_cnt), 32'd1);
    checkValue($sformatf("%s done latency", tag), 32'(done_cyc), 32'(ref_cyc + 1));
    checkValue($sformatf("%s err", tag), 32'(err), 32'(v.exp_err));
    checkValue($sformatf("%s busy idle", tag), 32'(busy), 32'd0);
  endtask

  function automatic vec_t mkVec(input logic [9:0] l, input logic [2:0] nb,
                                 input logic [31:0] b, input logic e);
    vec_t v;
    v         = '0;
    v.len     = l;
    v.n_bytes = nb;
    v.bytes   = b;
    v.exp_err = e;
    return v;
  endfunction

  task automatic addChunk(input int vi, input logic [11:0] b, input logic [3:0] w);
    vecs[vi].bits[vecs[vi].n_chunks[2:0]]   = b;
    vecs[vi].widths[vecs[vi].n_chunks[2:0]] = w;
    vecs[vi].n_chunks = vecs[vi].n_chunks + 4'd1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkValue({tag, " in_ready"},  32'(in_ready),  32'd0);
    checkValue({tag, " out_valid"}, 32'(out_valid), 32'd0);
    checkValue({tag, " out_byte"},  32'(out_byte),  32'd0);
    checkValue({tag, " out_last"},  32'(out_last),  32'd0);
    checkValue({tag, " busy"},      32'(busy),      32'd0);
    checkValue({tag, " done"},      32'(done),      32'd0);
    checkValue({tag, " err"},       32'(err),       32'd0);
  endtask

  initial begin
    vecs[0] = mkVec(10'd2, 3'd2, 32'h0000D719, 1'b0);
    addChunk(0, 12'h019, 4'd8);
    addChunk(0, 12'h0D7, 4'd8);
    vecs[1] = mkVec(10'd3, 3'd3, 32'h00D74719, 1'b0);
    addChunk(1, 12'h719, 4'd12);
    addChunk(1, 12'hD74, 4'd12);
    vecs[2] = mkVec(10'd1, 3'd1, 32'h00000019, 1'b0);
    addChunk(2, 12'h1, 4'd1);
    addChunk(2, 12'h0, 4'd1);
    addChunk(2, 12'h0, 4'd1);
    addChunk(2, 12'h1, 4'd1);
    addChunk(2, 12'h1, 4'd1);
    addChunk(2, 12'h0, 4'd1);
    addChunk(2, 12'h0, 4'd1);
    addChunk(2, 12'h0, 4'd1);
    vecs[3] = mkVec(10'd0, 3'd0, 32'h0, 1'b1);
    vecs[4] = mkVec(10'd1, 3'd1, 32'h000000BC, 1'b1);
    addChunk(4, 12'hABC, 4'd12);
    vecs[5] = mkVec(10'd2, 3'd2, 32'h00006A9D, 1'b0);
    addChunk(5, 12'h005, 4'd3);
    addChunk(5, 12'h013, 4'd5);
    addChunk(5, 12'h00A, 4'd4);
    addChunk(5, 12'h006, 4'd4);
    vecs[6] = mkVec(10'd1, 3'd1, 32'h0000005A, 1'b1);
    addChunk(6, 12'hFFF, 4'd0);
    addChunk(6, 12'hFFF, 4'd13);
    addChunk(6, 12'h05A, 4'd8);
    vecs[7] = mkVec(10'd2, 3'd2, 32'h0000F345, 1'b1);
    addChunk(7, 12'h345, 4'd12);
    addChunk(7, 12'hFFF, 4'd12);

    clearCapture();
    rst_n = 1'b0;
    tick();
    tick();
    checkResetOutputs("reset");
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v]);
      checkOutput(vecs[v], $sformatf("vec%0d", v));
    end

    // Backpressure: the first byte must sit unchanged while out_ready is low.
    out_ready = 1'b0;
    startFrame(10'd2);
    sendChunk(12'h019, 4'd8);
    for (int i = 0; i < 5; i++) begin
      checkValue($sformatf("bp valid %0d", i),    32'(out_valid), 32'd1);
      checkValue($sformatf("bp byte %0d", i),     32'(out_byte),  32'h19);
      checkValue($sformatf("bp in_ready %0d", i), 32'(in_ready),  32'd0);
      checkValue($sformatf("bp last %0d", i),     32'(out_last),  32'd0);
      tick();
    end
    out_ready = 1'b1;
    sendChunk(12'h0D7, 4'd8);
    waitDone();
    checkOutput(vecs[0], "bp");

    // Reset after the first byte of a three-byte frame.
    startFrame(10'd3);
    sendChunk(12'h719, 4'd12);
    tick();
    checkValue("mid first byte count", 32'(got_bytes.size()), 32'd1);
    if (got_bytes.size() > 0) checkValue("mid first byte", 32'(got_bytes[0]), 32'h19);
    rst_n = 1'b0;
    tick();
    checkResetOutputs("mid reset");
    rst_n = 1'b1;
    clearCapture();
    for (int i = 0; i < 4; i++) tick();
    checkValue("mid no bytes after reset", 32'(got_bytes.size()), 32'd0);
    checkValue("mid no done after reset",  32'(done_cnt),         32'd0);
    applyStimulus(vecs[1]);
    checkOutput(vecs[1], "post reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
